serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port a, input, WIDTH bits: minuend, unsigned.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend, unsigned.
REQ-007 SHALL have port in_valid, input, 1 bit: a and b are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-009 SHALL have port y, output, WIDTH bits: difference (a - b) mod 2^WIDTH.
REQ-010 SHALL have port bout, output, 1 bit: final borrow; 1 iff a < b.
REQ-011 SHALL have port out_valid, output, 1 bit: y and bout are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.

Function
REQ-013 SHALL implement FSM with states IDLE, RUN and DONE.
REQ-014 IDLE: in_ready=1 and out_valid=0; on an edge with in_valid=1, SHALL register a and b, clear the digit counter and borrow, and move to RUN.
REQ-015 IDLE with in_valid=0: SHALL remain in IDLE; y and bout hold their last values.
REQ-016 RUN: each edge SHALL subtract digit k (bits k*DIGIT..k*DIGIT+DIGIT-1) with the registered borrow, write that digit of y, update the borrow and increment k.
REQ-017 On the RUN edge processing the last digit (k = WIDTH/DIGIT-1), SHALL load bout from the final borrow and move to DONE.
REQ-018 Latency SHALL be exactly WIDTH/DIGIT edges from the accepting edge to the edge that raises out_valid; with defaults this is 8 edges.
REQ-019 DONE: out_valid=1 and in_ready=0; y and bout SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 DONE with out_ready=1 at an edge: SHALL move to IDLE and drop out_valid; y and bout hold.
REQ-021 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored and operands not re-sampled.
REQ-022 Changes on a and b after the accepting edge SHALL NOT affect the result.
REQ-023 No overlap: the earliest next accept SHALL be the edge after the completing edge.
REQ-024 Wrap-around: the result SHALL be modular. Example: 0 - 1 gives y = all ones, bout = 1.
REQ-025 Equal operands SHALL give y = 0 and bout = 0.

Reset
REQ-026 With rst=1 at an edge, SHALL enter IDLE and clear y, bout, out_valid, the digit counter and the internal borrow; in_ready=1 from the following cycle.
REQ-027 Reset SHALL take priority over every handshake event.
REQ-028 Reset during RUN or DONE SHALL discard the operation in progress and produce no out_valid for it.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration and the default WIDTH and DIGIT constants.
REQ-030 Sub-module digit_sub SHALL hold the DIGIT-bit combinational slice:
- inputs: digit of a, digit of b, borrow-in
- outputs: difference digit, borrow-out
REQ-031 serial_subtractor SHALL instantiate exactly one digit_sub.

Verification
REQ-032 Basic case: a=5, b=3, in_valid pulsed in IDLE, out_ready=1 -> out_valid rises exactly 8 edges after accept, y=2, bout=0.
REQ-033 Wrap-around: a=1, b=2 -> y=0xFFFFFFFF, bout=1; a=0, b=0 -> y=0, bout=0.
REQ-034 Borrow across digits: a=0x80000000, b=1 -> y=0x7FFFFFFF, bout=0; a=0x12345678, b=0x12345679 -> y=0xFFFFFFFF, bout=1.
REQ-035 Backpressure and ignored input: out_ready=0 for 5 cycles in DONE -> out_valid, y and bout stable; in_valid with new operands during RUN/DONE -> ignored, in_ready=0.
REQ-036 Reset mid-operation: rst pulsed 3 edges after accept -> IDLE, out_valid never asserted, y=0, bout=0; a new request afterwards (a=10, b=4) -> y=6 after 8 edges.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state enumeration and default sizing for the serial subtractor
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DIGIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_digit_sub.sv
// rtl/serial_subtractor_digit_sub.sv - one DIGIT-bit combinational subtract slice with borrow in/out
module digit_sub #(
    parameter int DIGIT = serial_subtractor_pkg::DEFAULT_DIGIT
) (
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    input  logic             bin,
    output logic [DIGIT-1:0] d_dig,
    output logic             bout
);

    logic [DIGIT:0] diff_full;

    // The extra top bit goes to 1 exactly when a_dig - b_dig - bin is negative.
    assign diff_full = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, bin};
    assign d_dig     = diff_full[DIGIT-1:0];
    assign bout      = diff_full[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial unsigned subtractor with valid/ready handshakes
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             bout,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_K = CW'(NDIG - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] y_q, y_d;
    logic             bout_q;
    logic             borrow_q;
    logic [CW-1:0]    k_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [DIGIT-1:0] a_dig, b_dig, d_dig;
    logic             borrow_d;

    // Digit mux and in-place write of digit k, built from constant slices.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        y_d   = y_q;
        for (int i = 0; i < NDIG; i++) begin
            if (k_q == CW'(i)) begin
                a_dig = a_q[i*DIGIT +: DIGIT];
                b_dig = b_q[i*DIGIT +: DIGIT];
                y_d[i*DIGIT +: DIGIT] = d_dig;
            end
        end
    end

    digit_sub #(
        .DIGIT(DIGIT)
    ) u_digit_sub (
        .a_dig(a_dig),
        .b_dig(b_dig),
        .bin  (borrow_q),
        .d_dig(d_dig),
        .bout (borrow_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            y_q         <= '0;
            bout_q      <= 1'b0;
            borrow_q    <= 1'b0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        k_q        <= '0;
                        borrow_q   <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    y_q      <= y_d;
                    borrow_q <= borrow_d;
                    k_q      <= k_q + 1'b1;
                    if (k_q == LAST_K) begin
                        bout_q      <= borrow_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign bout      = bout_q;

endmodule
